// File: rtl/mem_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_rr_if
//  Purpose  : Bundle of requester-side and RAM-side signals of the
//             round-robin memory arbiter.
//  Ports    : (interface signals)
//             ch_req/ch_wen/ch_addr/ch_wdata/ch_be - per-channel requests
//             ch_done/ch_rdata/ch_err              - per-channel completion
//             mem_req/mem_wen/mem_addr/mem_wdata/mem_be, mem_ack/mem_rdata
//  Modports : master - the arbiter (drives the RAM bus and completions)
//             slave  - the environment (requesters and the RAM)
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_rr_if #(
  parameter int N_CH = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  // Requester side, channel i occupies slice [i*W +: W] of each packed bus
  logic [N_CH-1:0]        ch_req;
  logic [N_CH-1:0]        ch_wen;
  logic [N_CH*AW-1:0]     ch_addr;
  logic [N_CH*DW-1:0]     ch_wdata;
  logic [N_CH*(DW/8)-1:0] ch_be;
  logic [N_CH-1:0]        ch_done;
  logic [DW-1:0]          ch_rdata;
  logic [N_CH-1:0]        ch_err;

  // RAM side
  logic                   mem_req;
  logic                   mem_wen;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_wdata;
  logic [DW/8-1:0]        mem_be;
  logic                   mem_ack;
  logic [DW-1:0]          mem_rdata;

  modport master (
    input  ch_req, ch_wen, ch_addr, ch_wdata, ch_be,
    input  mem_ack, mem_rdata,
    output ch_done, ch_rdata, ch_err,
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    output ch_req, ch_wen, ch_addr, ch_wdata, ch_be,
    output mem_ack, mem_rdata,
    input  ch_done, ch_rdata, ch_err,
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_be
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_rr
//  Purpose  : N-channel round-robin arbiter in front of a single-port RAM.
//             One transaction in flight; the granted request is latched into
//             the mem_* registers and held until mem_ack, then the channel
//             gets a one-cycle ch_done pulse with the read data (0 on writes).
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - mem_arbiter_rr_if.master (channel and RAM signals)
//  Options  : MEM_ARB_TIMEOUT_EN - when defined, a BUSY phase without
//             mem_ack for TIMEOUT cycles completes with ch_done+ch_err and
//             zero read data. When undefined, BUSY waits indefinitely and
//             ch_err is constant 0.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr #(
  parameter int N_CH    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input wire               clk,
  input wire               rst,
  mem_arbiter_rr_if.master bus
);

  localparam int BW = DW / 8;
  localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Stop elaboration on configurations the arbiter is not built for
  if (N_CH < 2 || N_CH > 8 || (DW % 8) != 0 || TIMEOUT < 2) begin : g_bad_params
    $error("mem_arbiter_rr: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q,     state_d;
  logic [GW-1:0]   ptr_q,       ptr_d;
  logic [GW-1:0]   grant_q,     grant_d;
  logic            mem_req_q,   mem_req_d;
  logic            mem_wen_q,   mem_wen_d;
  logic [AW-1:0]   mem_addr_q,  mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]   mem_be_q,    mem_be_d;
  logic [N_CH-1:0] done_q,      done_d;
  logic [DW-1:0]   rdata_q,     rdata_d;

  logic [N_CH-1:0] grant_oh;
  logic            req_any;
  logic [GW-1:0]   req_pick;
  int              rr_idx;

  // Unpacked per-channel views keep the grant mux a plain array index
  logic [AW-1:0]   ch_addr_a  [N_CH];
  logic [DW-1:0]   ch_wdata_a [N_CH];
  logic [BW-1:0]   ch_be_a    [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign ch_addr_a[i]  = bus.ch_addr[i*AW +: AW];
    assign ch_wdata_a[i] = bus.ch_wdata[i*DW +: DW];
    assign ch_be_a[i]    = bus.ch_be[i*BW +: BW];
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic            timeout_hit;
  logic [N_CH-1:0] err_q, err_d;

  // The counter holds the number of completed BUSY cycles without ack;
  // the cycle that would bring it to TIMEOUT ends the wait.
  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (cnt_inc == CW'(TIMEOUT));
`endif

  assign grant_oh = N_CH'(1) << grant_q;

  // Round-robin search: walk the offsets from the top down so the smallest
  // offset from ptr that has a request is the last (winning) assignment.
  always_comb begin
    req_any  = 1'b0;
    req_pick = '0;
    rr_idx   = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      rr_idx = int'(ptr_q) + k;
      if (rr_idx >= N_CH) begin
        rr_idx = rr_idx - N_CH;
      end
      if (bus.ch_req[GW'(rr_idx)]) begin
        req_any  = 1'b1;
        req_pick = GW'(rr_idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    mem_req_d   = mem_req_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    done_d      = '0;
    rdata_d     = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          grant_d     = req_pick;
          mem_req_d   = 1'b1;
          mem_wen_d   = bus.ch_wen[req_pick];
          mem_addr_d  = ch_addr_a[req_pick];
          mem_wdata_d = ch_wdata_a[req_pick];
          mem_be_d    = ch_be_a[req_pick];
          state_d     = S_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end

      S_BUSY: begin
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d = cnt_inc;
`endif
        // An ack arriving in the timeout cycle still completes normally
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          rdata_d   = mem_wen_q ? '0 : bus.mem_rdata;
          done_d    = grant_oh;
          state_d   = S_RESP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          mem_req_d = 1'b0;
          rdata_d   = '0;
          done_d    = grant_oh;
          err_d     = grant_oh;
          state_d   = S_RESP;
        end
`endif
      end

      S_RESP: begin
        // Served channel becomes lowest priority for the next search
        ptr_d   = (grant_q == GW'(N_CH - 1)) ? '0 : grant_q + 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      mem_req_q   <= mem_req_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.ch_done   = done_q;
  assign bus.ch_rdata  = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.ch_err    = err_q;
`else
  assign bus.ch_err    = '0;
`endif

endmodule
`default_nettype wire
